// File: rtl/rtc_core.sv
// Real-time-clock core: prescaled seconds/minutes/hours with edge-triggered setting,
// a daily alarm with timeout, and 12/24-hour BCD display outputs.
module rtc_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode12,
    input  logic       hrup,
    input  logic       minup,
    input  logic       secclr,
    input  logic       alarm_set,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] m1,
    output logic [3:0] m2,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic       pm,
    output logic       alarm,
    output logic       tick
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int CW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALARM_SECS);

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    amin_q, amin_d;
    logic [4:0]    ahour_q, ahour_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alarm_q, alarm_d;
    logic          tick_q, tick_d;
    logic          tupd_q, tupd_d;
    logic          hrup_q, minup_q;

    logic hr_edge, min_edge, time_adj, wrap;

    // Binary 0-59 to {tens, ones} BCD.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] base;
        if (v >= 6'd50) begin
            tens = 4'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1; base = 6'd10;
        end else begin
            tens = 4'd0; base = 6'd0;
        end
        return {tens, 4'(v - base)};
    endfunction

    always_comb begin
        pre_d   = pre_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        amin_d  = amin_q;
        ahour_d = ahour_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        tupd_d  = 1'b0;

        hr_edge  = hrup & ~hrup_q;
        min_edge = minup & ~minup_q;
        time_adj = (hr_edge | min_edge) & ~alarm_set;
        wrap     = en && (pre_q == PRE_MAX) && !secclr;
        tick_d   = wrap;

        if (secclr)
            pre_d = '0;
        else if (en)
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;

        // An adjust edge swallows a coincident tick's time update.
        if (secclr) begin
            sec_d = 6'd0;
        end else if (time_adj) begin
            if (hr_edge)
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            if (min_edge)
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else if (wrap) begin
            tupd_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (alarm_set) begin
            if (hr_edge)
                ahour_d = (ahour_q == 5'd23) ? 5'd0 : ahour_q + 5'd1;
            if (min_edge)
                amin_d = (amin_q == 6'd59) ? 6'd0 : amin_q + 6'd1;
        end

        // Fire is judged on the registered tick so manual setting never matches.
        if (alarm_ack || !alarm_en) begin
            alarm_d = 1'b0;
            cnt_d   = '0;
        end else if (tupd_q && sec_q == 6'd0 && hour_q == ahour_q && min_q == amin_q) begin
            alarm_d = 1'b1;
            cnt_d   = CNT_LOAD;
        end else if (alarm_q && tick_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1))
                alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            amin_q  <= 6'd0;
            ahour_q <= 5'd0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            tick_q  <= 1'b0;
            tupd_q  <= 1'b0;
            hrup_q  <= 1'b0;
            minup_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            amin_q  <= amin_d;
            ahour_q <= ahour_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            tick_q  <= tick_d;
            tupd_q  <= tupd_d;
            hrup_q  <= hrup;
            minup_q <= minup;
        end
    end

    logic [4:0] disp_hour, hr_show;
    logic [5:0] disp_min, disp_sec;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;

    always_comb begin
        disp_hour = alarm_set ? ahour_q : hour_q;
        disp_min  = alarm_set ? amin_q : min_q;
        disp_sec  = alarm_set ? 6'd0 : sec_q;
        hr_show   = disp_hour;
        pm        = 1'b0;
        if (mode12) begin
            if (disp_hour == 5'd0) begin
                hr_show = 5'd12;
            end else if (disp_hour >= 5'd12) begin
                pm = 1'b1;
                if (disp_hour > 5'd12)
                    hr_show = disp_hour - 5'd12;
            end
        end
        sec_bcd  = to_bcd(disp_sec);
        min_bcd  = to_bcd(disp_min);
        hour_bcd = to_bcd({1'b0, hr_show});
        {s2, s1} = sec_bcd;
        {m2, m1} = min_bcd;
        {h2, h1} = hour_bcd;
    end

    assign alarm = alarm_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_rtc_core.sv
// Bench for rtc_core: directed scenarios plus random traffic, every cycle compared
// against a seconds-of-day reference model.
module tb_rtc_core;

    localparam int CLK_HZ     = 10;
    localparam int ALARM_SECS = 3;

    logic clk = 1'b0;
    logic rst, en, mode12, hrup, minup, secclr, alarm_set, alarm_en, alarm_ack;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic pm, alarm, tick;

    rtc_core #(.CLK_HZ(CLK_HZ), .ALARM_SECS(ALARM_SECS)) dut (
        .clk(clk), .rst(rst), .en(en), .mode12(mode12), .hrup(hrup), .minup(minup),
        .secclr(secclr), .alarm_set(alarm_set), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .pm(pm), .alarm(alarm), .tick(tick)
    );

    always #5 clk = ~clk;

    logic [23:0] digits;
    assign digits = {h2, h1, m2, m1, s2, s1};

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: time as seconds of day, alarm as minute of day.
    int m_t = 0, m_pc = 0, m_am = 0, m_cnt = 0;
    bit m_al = 0, m_tick = 0, m_upd = 0, m_hp = 0, m_mp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [24:0] exp_disp(input int t, input int am, input bit aset, input bit m12);
        int h, m, s;
        bit p;
        h = aset ? am / 60 : t / 3600;
        m = aset ? am % 60 : (t / 60) % 60;
        s = aset ? 0 : t % 60;
        p = 1'b0;
        if (m12) begin
            p = (h >= 12);
            h = (h % 12 == 0) ? 12 : h % 12;
        end
        return {p, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_edge();
        int h, m, s, ah, amn, n_cnt;
        bit he, me, wrap, n_al;
        if (rst) begin
            m_t = 0; m_pc = 0; m_am = 0; m_cnt = 0;
            m_al = 0; m_tick = 0; m_upd = 0; m_hp = 0; m_mp = 0;
        end else begin
            he   = hrup && !m_hp;
            me   = minup && !m_mp;
            wrap = en && (m_pc == CLK_HZ - 1) && !secclr;
            n_al = m_al;
            n_cnt = m_cnt;
            if (alarm_ack || !alarm_en) begin
                n_al = 0; n_cnt = 0;
            end else if (m_upd && (m_t % 60 == 0) && (m_t / 60 == m_am)) begin
                n_al = 1; n_cnt = ALARM_SECS;
            end else if (m_al && m_tick) begin
                n_cnt = m_cnt - 1;
                n_al = (n_cnt != 0);
            end
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
            m_upd = 0;
            if (secclr) begin
                s = 0;
            end else if ((he || me) && !alarm_set) begin
                if (he) h = (h + 1) % 24;
                if (me) m = (m + 1) % 60;
            end else if (wrap) begin
                m_upd = 1;
            end
            m_t = (h * 3600 + m * 60 + s + (m_upd ? 1 : 0)) % 86400;
            if (alarm_set) begin
                ah = m_am / 60; amn = m_am % 60;
                if (he) ah = (ah + 1) % 24;
                if (me) amn = (amn + 1) % 60;
                m_am = ah * 60 + amn;
            end
            if (secclr) m_pc = 0;
            else if (en) m_pc = (m_pc == CLK_HZ - 1) ? 0 : m_pc + 1;
            m_tick = wrap;
            m_hp = hrup; m_mp = minup;
            m_al = n_al; m_cnt = n_cnt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {5'd0, tick, alarm, pm, digits},
            {5'd0, m_tick, m_al, exp_disp(m_t, m_am, alarm_set, mode12)});
    endtask

    task automatic press_hr(input int n);
        repeat (n) begin hrup = 1'b1; step(); hrup = 1'b0; step(); end
    endtask

    task automatic press_mn(input int n);
        repeat (n) begin minup = 1'b1; step(); minup = 1'b0; step(); end
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; mode12 = 1'b0; hrup = 1'b0; minup = 1'b0; secclr = 1'b0;
        alarm_set = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out", {tick, alarm, pm, digits}, 27'd0);
        mode12 = 1'b1; #1;
        chk("rst_12h", {pm, digits}, {1'b0, 24'h120000});
        mode12 = 1'b0;

        // Tick cadence and minute carry
        rst = 1'b0; en = 1'b1;
        repeat (9) step();
        chk("no_early_tick", tick, 1'b0);
        step();
        chk("first_tick", tick, 1'b1);
        repeat (590) step();
        chk("sixty_ticks", digits, 24'h000100);

        // 23:59:59 rolls to midnight
        en = 1'b0;
        press_hr(23);
        press_mn(58);
        chk("preset_hm", digits, 24'h235900);
        en = 1'b1;
        repeat (590) step();
        chk("preset_full", digits, 24'h235959);
        repeat (10) step();
        chk("day_wrap", {tick, digits}, {1'b1, 24'h000000});

        // Held minup is one step, no hour carry; hour 23 wraps
        en = 1'b0;
        press_hr(10);
        press_mn(59);
        chk("at_1059", digits, 24'h105900);
        minup = 1'b1;
        repeat (50) step();
        minup = 1'b0;
        step();
        chk("min_nocarry", digits, 24'h100000);
        press_hr(13);
        chk("hour_23", digits, 24'h230000);
        press_hr(1);
        chk("hour_wrap", digits, 24'h000000);

        // 12-hour mapping
        mode12 = 1'b1; #1;
        chk("m12_h0", {pm, digits}, {1'b0, 24'h120000});
        press_hr(12);
        chk("m12_h12", {pm, digits}, {1'b1, 24'h120000});
        press_hr(1);
        chk("m12_h13", {pm, digits}, {1'b1, 24'h010000});
        mode12 = 1'b0; #1;
        chk("m24_h13", {pm, digits}, {1'b0, 24'h130000});

        // Alarm 07:30 fires and times out after ALARM_SECS ticks
        alarm_set = 1'b1;
        press_hr(7);
        press_mn(30);
        chk("alarm_disp", digits, 24'h073000);
        alarm_set = 1'b0;
        press_hr(18);
        press_mn(29);
        chk("time_0729", digits, 24'h072900);
        secclr = 1'b1; step(); secclr = 1'b0;
        alarm_en = 1'b1; en = 1'b1;
        repeat (590) step();
        chk("time_072959", digits, 24'h072959);
        repeat (10) step();
        chk("fire_tick", {tick, alarm, digits}, {2'b10, 24'h073000});
        step();
        chk("alarm_rise", alarm, 1'b1);
        repeat (29) step();
        chk("alarm_last_tick", {tick, alarm}, 2'b11);
        step();
        chk("alarm_timeout", alarm, 1'b0);

        // Second firing, cleared by ack
        alarm_set = 1'b1;
        press_mn(1);
        alarm_set = 1'b0;
        k = 0;
        while (alarm !== 1'b1 && k < 800) begin step(); k++; end
        chk("ack_fire_wait", k < 800, 1'b1);
        alarm_ack = 1'b1;
        step();
        chk("ack_clear", alarm, 1'b0);
        alarm_ack = 1'b0;

        // Alarm edit while time runs
        alarm_set = 1'b1; #1;
        chk("aset_view", digits, 24'h073100);
        press_hr(1);
        chk("aset_hr", digits, 24'h083100);
        repeat (20) step();
        alarm_set = 1'b0;
        step();

        // secclr mid-count and on a tick cycle
        alarm_en = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        repeat (27) step();
        chk("pre_secclr", digits, 24'h000002);
        secclr = 1'b1; step(); secclr = 1'b0;
        chk("secclr_mid", {tick, digits}, {1'b0, 24'h000000});
        repeat (9) step();
        chk("secclr_no_tick", tick, 1'b0);
        step();
        chk("secclr_next_tick", {tick, digits}, {1'b1, 24'h000001});
        repeat (9) step();
        secclr = 1'b1; step(); secclr = 1'b0;
        chk("secclr_on_tick", {tick, digits}, {1'b0, 24'h000000});
        repeat (9) step();
        step();
        chk("secclr_tick_after", tick, 1'b1);

        // Reset mid-count
        alarm_en = 1'b1;
        repeat (5) step();
        rst = 1'b1; step();
        chk("rst_mid", {tick, alarm, pm, digits}, 27'd0);
        rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 3) begin
                secclr = 1'b1;
            end else begin
                secclr = 1'b0;
                if ($urandom_range(0, 7) == 0) hrup = ~hrup;
                if ($urandom_range(0, 3) == 0) minup = ~minup;
            end
            if ($urandom_range(0, 49) == 0) mode12 = ~mode12;
            alarm_set = ($urandom_range(0, 9) == 0);
            alarm_en  = ($urandom_range(0, 19) != 0);
            alarm_ack = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
